// File: rtl/hyper_resp.sv
// HyperBus memory responder: decodes CA, inserts initial latency, serves burst
// reads/writes to a 2^ADDR_W x 16 memory and the cr0/ID register space.
module hyper_resp #(
  parameter int          ADDR_W = 10,
  parameter int          LAT_1X = 12,
  parameter logic [15:0] ID0    = 16'h0C81
) (
  input  logic       clk,
  input  logic       reset_l,
  input  logic       dram_cs_l,
  input  logic       dram_rst_l,
  input  logic [7:0] dram_dq_in,
  output logic [7:0] dram_dq_out,
  output logic       dram_dq_oe_l,
  input  logic       dram_rwds_in,
  output logic       dram_rwds_out,
  output logic       dram_rwds_oe_l
);
  localparam logic [15:0] CR0_RST = 16'h8F1F;
  localparam int          NW      = 7;
  localparam logic [NW-1:0] D1_LAST = NW'(LAT_1X - 1);
  localparam logic [NW-1:0] D2_LAST = NW'(2 * LAT_1X - 1);

  typedef enum logic [2:0] {IDLE, CA, LAT, RD, WR, REGW, DONE} state_t;
  typedef struct packed {
    logic rd;
    logic regsp;
    logic lin;
    logic hi_nz;  // register-space address bits above ADDR_W are non-zero
  } cmd_t;

  state_t            state;
  cmd_t              cmd, ca_cmd, pf_cmd;
  logic [15:0]       cr0;
  logic [39:0]       ca_sr;
  logic [NW-1:0]     n, d_last;
  logic [ADDR_W-1:0] addr, pf_addr;
  logic [15:0]       rd_word, pf_word;
  logic [7:0]        wr_hi;
  logic              wr_hi_m, byte_lo;
  logic [31:0]       ca_waddr;
  logic              is_regw, go_data, mem_we;
  logic [15:0]       mem [0:(1<<ADDR_W)-1];

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a, input logic lin);
    addr_inc = lin ? a + 1'b1 : {a[ADDR_W-1:4], a[3:0] + 4'd1};
  endfunction

  // CA byte 5 is still on dq_in when the command is decoded
  assign ca_waddr = {ca_sr[36:8], dram_dq_in[2:0]};
  assign d_last   = cr0[3] ? D2_LAST : D1_LAST;

  always_comb begin
    ca_cmd.rd    = ca_sr[39];
    ca_cmd.regsp = ca_sr[38];
    ca_cmd.lin   = ca_sr[37];
    ca_cmd.hi_nz = |ca_waddr[31:ADDR_W];
  end

  assign is_regw = !ca_cmd.rd && ca_cmd.regsp;
  assign go_data = (state == LAT || (state == CA && !is_regw)) && n == d_last;

  // Prefetch source: the live CA decode when latency is empty, else the burst address
  always_comb begin
    pf_addr = addr;
    pf_cmd  = cmd;
    if (state == CA) begin
      pf_addr = ca_waddr[ADDR_W-1:0];
      pf_cmd  = ca_cmd;
    end
    if (pf_cmd.regsp) pf_word = (!pf_cmd.hi_nz && pf_addr == '0) ? ID0 : cr0;
    else              pf_word = mem[pf_addr];
  end

  // A word commits only on its second byte, so an abort never leaves half a word
  assign mem_we = state == WR && byte_lo && !dram_cs_l && dram_rst_l;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (!wr_hi_m)      mem[addr][15:8] <= wr_hi;
      if (!dram_rwds_in) mem[addr][7:0]  <= dram_dq_in;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state          <= IDLE;
      cr0            <= CR0_RST;
      dram_dq_out    <= 8'h00;
      dram_dq_oe_l   <= 1'b1;
      dram_rwds_out  <= 1'b0;
      dram_rwds_oe_l <= 1'b1;
      cmd            <= '0;
      ca_sr          <= '0;
      n              <= '0;
      addr           <= '0;
      rd_word        <= '0;
      wr_hi          <= '0;
      wr_hi_m        <= 1'b1;
      byte_lo        <= 1'b0;
    end else if (!dram_rst_l) begin
      state          <= IDLE;
      cr0            <= CR0_RST;
      dram_dq_oe_l   <= 1'b1;
      dram_rwds_oe_l <= 1'b1;
    end else if (dram_cs_l) begin
      state          <= IDLE;
      dram_dq_oe_l   <= 1'b1;
      dram_rwds_oe_l <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          ca_sr          <= {32'h0, dram_dq_in};
          n              <= NW'(1);
          byte_lo        <= 1'b0;
          state          <= CA;
          dram_rwds_oe_l <= 1'b0;
          dram_rwds_out  <= cr0[3];
        end
        CA, LAT: begin
          dram_dq_oe_l <= 1'b1;
          n            <= n + 1'b1;
          if (state == CA) begin
            ca_sr <= {ca_sr[31:0], dram_dq_in};
            if (n == NW'(5)) begin
              cmd   <= ca_cmd;
              addr  <= ca_waddr[ADDR_W-1:0];
              state <= is_regw ? REGW : LAT;
            end
          end
          if (go_data) begin
            byte_lo <= 1'b0;
            state   <= pf_cmd.rd ? RD : WR;
            if (pf_cmd.rd) begin
              rd_word <= pf_word;
              addr    <= addr_inc(pf_addr, pf_cmd.lin);
            end
          end
        end
        RD: begin
          dram_dq_oe_l   <= 1'b0;
          dram_rwds_oe_l <= 1'b0;
          if (!byte_lo) begin
            dram_dq_out   <= rd_word[15:8];
            dram_rwds_out <= 1'b1;
            byte_lo       <= 1'b1;
          end else begin
            dram_dq_out   <= rd_word[7:0];
            dram_rwds_out <= 1'b0;
            byte_lo       <= 1'b0;
            rd_word       <= pf_word;
            addr          <= addr_inc(addr, cmd.lin);
          end
        end
        WR: begin
          dram_dq_oe_l   <= 1'b1;
          dram_rwds_oe_l <= 1'b1;
          if (!byte_lo) begin
            wr_hi   <= dram_dq_in;
            wr_hi_m <= dram_rwds_in;
            byte_lo <= 1'b1;
          end else begin
            byte_lo <= 1'b0;
            addr    <= addr_inc(addr, cmd.lin);
          end
        end
        REGW: begin
          dram_rwds_oe_l <= 1'b1;
          if (!byte_lo) begin
            wr_hi   <= dram_dq_in;
            byte_lo <= 1'b1;
          end else begin
            cr0   <= {wr_hi, dram_dq_in};
            state <= DONE;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
